// File: rtl/bit_serial_add.sv
// bit_serial_add -- bit-serial two-operand adder, LSB first.
//   One bit of each operand enters per clock and one sum bit leaves per clock.
//   The carry lives in the 1-bit register "state" between cycles.
//   After the MSB, one cycle of a=b=0 flushes the final carry onto q and
//   returns the carry to zero.
// Latency: zero cycles in the default build, where q is combinational
//   (Mealy). When BIT_SERIAL_ADD_REGOUT_EN is defined, q is registered and
//   sum bit i is valid after edge i.
// Backpressure: none. The caller presents one bit pair on every clock.
//
// Ports:
//   clk    system clock; all state updates occur on the rising edge
//   reset  asynchronous, active-high; clears the carry (and q when registered)
//   a, b   operand bits, LSB first, sampled on each rising edge
//   q      serial sum bit
//
// Optional build macro: BIT_SERIAL_ADD_REGOUT_EN (registered q output).

module bit_serial_add (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic q
);

   typedef enum logic {
      S0 = 1'b0,   // no carry
      S1 = 1'b1    // carry pending
   } state_t;

   state_t state;
   state_t state_next;
   logic   carry;
   logic   sum;

   assign carry = state;
   assign sum   = a ^ b ^ carry;

   // Carry register. Reset acts immediately, so a carry from an
   // interrupted word never leaks into the next sum bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S0;
      end else begin
         state <= state_next;
      end
   end

   // Next state is the majority of a, b and the current carry. This moves
   // S0->S1 on a&b and S1->S0 on ~a&~b, and otherwise holds. It is written
   // as a boolean expression rather than a case on state so that an X on
   // a or b reaches the carry instead of being masked by an if/else.
   always_comb begin
      state_next = state;
      state_next = state_t'((a & b) | (a & carry) | (b & carry));
   end

`ifdef BIT_SERIAL_ADD_REGOUT_EN
   // Registered sum. It is captured on the same edge as the carry update,
   // so bit i appears one cycle after its operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         q <= sum;
      end
   end
`else
   // Mealy output. It is valid in the same cycle that a/b are presented.
   assign q = sum;
`endif

endmodule

// File: tb/tb_bit_serial_add.sv
// Self-checking bench for bit_serial_add. Directed bit pairs with hand-computed
// sum and carry values. It supports both the default build and the
// BIT_SERIAL_ADD_REGOUT_EN build.
// Ports exercised: clk, reset, a, b, q (plus the internal carry register).

module tb_bit_serial_add;

   logic clk;
   logic reset;
   logic a;
   logic b;
   logic q;

   int vectors;
   int miscompares;

   bit_serial_add dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one bit pair at the falling edge. The caller supplies the expected
   // sum bit for this pair and the expected carry after the next rising edge.
   task automatic step(input logic ai, input logic bi,
                       input logic exp_q, input logic exp_state,
                       input string tag);
      @(negedge clk);
      a = ai;
      b = bi;
      #1;
`ifndef BIT_SERIAL_ADD_REGOUT_EN
      chk({tag, " q"}, q, exp_q);
`endif
      @(posedge clk);
      #1;
`ifdef BIT_SERIAL_ADD_REGOUT_EN
      chk({tag, " q"}, q, exp_q);
`endif
      chk({tag, " state"}, dut.state, exp_state);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      a           = 1'b1;
      b           = 1'b1;

      // 1. Reset hold with a=b=1. The carry stays clear and q is 0:
      //    comb q = 1^1^0 = 0, and the registered q is cleared by reset.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("rst_hold q", q, 1'b0);
         chk("rst_hold state", dut.state, 1'b0);
      end
      @(negedge clk);
      a     = 1'b0;
      b     = 1'b0;
      reset = 1'b0;

      // 2. 11 + 9 = 20: pairs 1/1, 1/0, 0/0, 1/1, then a flush.
      step(1'b1, 1'b1, 1'b0, 1'b1, "add11_9 b0");
      step(1'b1, 1'b0, 1'b0, 1'b1, "add11_9 b1");
      step(1'b0, 1'b0, 1'b1, 1'b0, "add11_9 b2");
      step(1'b1, 1'b1, 1'b0, 1'b1, "add11_9 b3");
      step(1'b0, 1'b0, 1'b1, 1'b0, "add11_9 flush");

      // 3. Carry ripple: 1111 + 0001 = 10000.
      step(1'b1, 1'b1, 1'b0, 1'b1, "ripple b0");
      step(1'b1, 1'b0, 1'b0, 1'b1, "ripple b1");
      step(1'b1, 1'b0, 1'b0, 1'b1, "ripple b2");
      step(1'b1, 1'b0, 1'b0, 1'b1, "ripple b3");
      step(1'b0, 1'b0, 1'b1, 1'b0, "ripple flush");

      // 4. Zero operands from S0.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, "zeros");
      end

      // 5. Asynchronous reset in the middle of a word.
      step(1'b1, 1'b1, 1'b0, 1'b1, "midrst set");
      @(negedge clk);
      a = 1'b1;
      b = 1'b0;
      #1;
      // Comb: 1^0^1 = 0. Registered: the sum from the previous edge, 1^1^0 = 0.
      chk("midrst q before", q, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst state async", dut.state, 1'b0);
`ifdef BIT_SERIAL_ADD_REGOUT_EN
      chk("midrst q async", q, 1'b0);
`else
      chk("midrst q async", q, 1'b1);
`endif
      @(posedge clk);
      #1;
      chk("midrst state held", dut.state, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      // The new word starts with no carry: 1+0 = 1, then 1+1 = 0 with a carry.
      step(1'b1, 1'b0, 1'b1, 1'b0, "postrst b0");
      step(1'b1, 1'b1, 1'b0, 1'b1, "postrst b1");
      step(1'b0, 1'b0, 1'b1, 1'b0, "postrst flush");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bit_serial_add.md
Name: bit_serial_add

Overview:
- Bit-serial two-operand adder, LSB first: one bit of each operand per clock, one sum bit out per clock.
- The carry is held in a 1-bit state register between cycles.
- Operands of any length are streamed back to back. After the last operand bit, driving 0/0 for one extra cycle flushes the final carry onto q.
- Building block for serial datapaths; operand framing is the caller's job.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset; clears the carry state
- a  input  1  operand A serial bit, LSB first, sampled each cycle
- b  input  1  operand B serial bit, LSB first, sampled each cycle
- q  output  1  serial sum bit for the current a/b pair

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- State register, named "state", 1 bit, holds the carry. Two states:
  - S0 (no carry) = 0
  - S1 (carry pending) = 1
- Reset: state forced to S0 immediately on reset high, independent of clk. It stays S0 while reset is high.
- Output (default build, Mealy): q = a XOR b XOR state, purely combinational. It is valid in the same cycle a/b are presented, with zero latency.
- During reset q = a XOR b, because state = S0.
- Transitions on rising clk edge when reset is low:
  - S0 -> S1 iff a AND b; otherwise stay S0.
  - S1 -> S0 iff NOT a AND NOT b; otherwise stay S1.
  - Equivalent rule: state_next = majority(a, b, state).
- Caller contract: present bit i of both operands before rising edge i. q for bit i is sampled before that edge.
- Word boundaries:
  - No internal word counter.
  - To start an independent addition, either the carry must already be 0 or reset must be pulsed.
  - One cycle of a=b=0 after the MSB emits the final carry and returns to S0.
- Reset mid-operation: the carry is lost immediately. The next sum bits are computed as if a new word starts.
- Inputs a/b must be stable around the rising edge (synchronous inputs). X on a/b propagates to q and state; no masking.
- No overflow flag; width is unbounded.

Optional Feature:
- Macro: BIT_SERIAL_ADD_REGOUT_EN
- Defined:
  - q is registered: on each rising edge, q <= a XOR b XOR state, in parallel with the state update.
  - Sum bit i therefore appears one cycle later, valid after edge i.
  - Reset clears q to 0 asynchronously, together with state.
  - The flush cycle still needs a=b=0 for one cycle, plus one extra cycle to observe the result.
- Not defined: combinational Mealy output as specified above.
- State-transition behaviour is identical in both builds.

Test Plan:
1. Reset hold: reset=1 for 2 cycles with a=1,b=1 -> state stays 0 and q=0 (default build). With the macro, q=0.
2. 11 + 9 (A=1011, B=1001 LSB first; bit pairs 1/1, 1/0, 0/0, 1/1) followed by 0/0 -> q sequence 0,0,1,0,1 (=10100b=20). State after each edge: 1,1,0,1,0.
3. Carry ripple: 1111 + 0001, then flush 0/0 -> q = 0,0,0,0,1. State stays 1 for four edges, then returns to 0.
4. Zero operands: a=b=0 for 4 cycles from S0 -> q=0 throughout, state 0.
5. Async reset mid-word: reach state=1 (a=b=1 edge), assert reset between edges -> state drops to 0 before the next edge. With a=1,b=0, q changes 0 -> 1 immediately.
6. With BIT_SERIAL_ADD_REGOUT_EN defined, rerun scenario 2 -> same q sequence 0,0,1,0,1, each bit one cycle later. q=0 during reset.
